// File: rtl/weight_stream_pkg.sv
// Shared defaults for the weight prefetch streamer and a helper that
// locates a weight lane inside a packed ROM word.
package weight_stream_pkg;

  localparam int unsigned DEFAULT_PRECISION   = 16;
  localparam int unsigned DEFAULT_PARALLELISM = 1;
  localparam int unsigned DEFAULT_OUT_DEPTH   = 32;
  localparam int unsigned DEFAULT_ROM_LATENCY = 2;
  localparam int unsigned DEFAULT_FIFO_DEPTH  = 4;

  // Bit offset of lane `lane` in a word of `precision`-bit lanes.
  function automatic int unsigned lane_offset(input int unsigned lane,
                                              input int unsigned precision);
    return lane * precision;
  endfunction

endpackage

// File: rtl/sync_fifo_lastbit.sv
// Synchronous landing FIFO for ROM words plus their end-of-pass flag.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   wr_en_i, wdata_i write strobe and {last, word}
//   rd_en_i, rdata_o pop strobe and head entry (no write-to-read bypass)
//   count_o          current occupancy
//   full_o, empty_o  occupancy flags
// A write while full is only accepted together with a read.
module sync_fifo_lastbit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [WIDTH:0]             wdata_i,
  input  logic                       rd_en_i,
  output logic [WIDTH:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH:0] mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           wr_ok, rd_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/weight_prefetch_streamer.sv
// Streams dense weights from a fixed-latency ROM to a valid/ready consumer.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rom_addr, rom_ce    registered ROM address, chip enable (always on)
//   rom_q               ROM read data, ROM_LATENCY cycles after sampling
//   data_out            per-lane weights from the FIFO head
//   data_out_valid/ready/last  output stream; last marks address OUT_DEPTH-1
//   pass_count          number of completed tensor passes (wraps)
module weight_prefetch_streamer
  import weight_stream_pkg::*;
#(
  parameter int unsigned WEIGHT_PRECISION_0 = DEFAULT_PRECISION,
  parameter int unsigned WEIGHT_PARALLELISM = DEFAULT_PARALLELISM,
  parameter int unsigned OUT_DEPTH          = DEFAULT_OUT_DEPTH,
  parameter int unsigned ROM_LATENCY        = DEFAULT_ROM_LATENCY,
  parameter int unsigned FIFO_DEPTH         = DEFAULT_FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH         = $clog2(OUT_DEPTH) + 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  output logic [ADDR_WIDTH-1:0]                            rom_addr,
  output logic                                             rom_ce,
  input  logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM-1:0] rom_q,
  output logic [WEIGHT_PRECISION_0-1:0]                    data_out [WEIGHT_PARALLELISM],
  output logic                                             data_out_valid,
  input  logic                                             data_out_ready,
  output logic                                             data_out_last,
  output logic [15:0]                                      pass_count
);

  localparam int unsigned WORD_W = WEIGHT_PRECISION_0 * WEIGHT_PARALLELISM;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + ROM_LATENCY + 2) + 1;

  if (FIFO_DEPTH < ROM_LATENCY + 2) begin : g_depth_check
    $error("FIFO_DEPTH must be at least ROM_LATENCY+2");
  end

  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ROM_LATENCY-1:0] issue_q, issue_d;
  logic [ROM_LATENCY-1:0] last_q, last_d;
  logic                   ret_valid_q, ret_last_q;
  logic [15:0]            pass_q, pass_d;

  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full, fifo_empty;
  logic [WORD_W:0]        fifo_rdata;
  logic [WORD_W-1:0]      head_word;
  logic                   head_last;
  logic                   rd, issue, at_end;
  logic [OCC_W-1:0]       occ;

  sync_fifo_lastbit #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .wr_en_i (ret_valid_q),
    .wdata_i ({ret_last_q, rom_q}),
    .rd_en_i (rd),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_last      = fifo_rdata[WORD_W];
  assign head_word      = fifo_rdata[WORD_W-1:0];
  assign data_out_valid = !fifo_empty;
  assign data_out_last  = data_out_valid && head_last;
  assign rd             = data_out_valid && data_out_ready;
  assign rom_addr       = addr_q;
  assign rom_ce         = 1'b1;
  assign pass_count     = pass_q;

  // Occupancy counts every word already committed: FIFO contents, the word
  // landing this cycle, and ROM reads in flight. The word popped this cycle
  // is released immediately; that keeps the bound exact (never overflows)
  // while letting a depth of ROM_LATENCY+2 sustain one word per cycle.
  always_comb begin
    occ    = OCC_W'(fifo_count) + OCC_W'(ret_valid_q)
           + OCC_W'($countones(issue_q)) - OCC_W'(rd);
    issue  = (occ < OCC_W'(FIFO_DEPTH));
    at_end = (addr_q == ADDR_WIDTH'(OUT_DEPTH - 1));
    addr_d = addr_q;
    if (issue) addr_d = at_end ? '0 : addr_q + 1'b1;
    issue_d = (issue_q << 1) | ROM_LATENCY'(issue);
    last_d  = (last_q << 1) | ROM_LATENCY'(issue && at_end);
    pass_d  = pass_q + 16'(rd && head_last);
  end

  // The extra ret_* stage aligns the issue marker with rom_q, which the ROM
  // presents one cycle after the shift register's output bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      issue_q     <= '0;
      last_q      <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      pass_q      <= '0;
    end else begin
      addr_q      <= addr_d;
      issue_q     <= issue_d;
      last_q      <= last_d;
      ret_valid_q <= issue_q[ROM_LATENCY-1];
      ret_last_q  <= last_q[ROM_LATENCY-1];
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < WEIGHT_PARALLELISM; j++) begin
      data_out[j] = head_word[lane_offset(j, WEIGHT_PRECISION_0) +: WEIGHT_PRECISION_0];
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(ret_valid_q && fifo_full && !rd));

endmodule

// File: tb/tb_weight_prefetch_streamer.sv
module tb_weight_prefetch_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  rom_addr;
  logic        rom_ce;
  logic [63:0] rom_q = '0;
  logic [15:0] data_out [4];
  logic        data_out_valid;
  logic        data_out_ready;
  logic        data_out_last;
  logic [15:0] pass_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  weight_prefetch_streamer #(
    .WEIGHT_PRECISION_0 (16),
    .WEIGHT_PARALLELISM (4),
    .OUT_DEPTH          (32),
    .ROM_LATENCY        (2),
    .FIFO_DEPTH         (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_ce         (rom_ce),
    .rom_q          (rom_q),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last),
    .pass_count     (pass_count)
  );

  // ROM contents: lane j of word a holds a*16 + 0xA + j, so word 0 is
  // {16'h0D,16'h0C,16'h0B,16'h0A} and every word is distinct.
  function automatic logic [63:0] exp_word(input int unsigned a);
    logic [63:0] w;
    for (int j = 0; j < 4; j++) w[16*j +: 16] = 16'(a * 16 + 10 + j);
    return w;
  endfunction

  // Address sampled at an edge, data out two edges later.
  logic [5:0]  rom_a_q  = '0;
  logic [63:0] rom_d1_q = '0;
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_a_q  <= rom_addr;
      rom_d1_q <= exp_word(rom_a_q);
      rom_q    <= rom_d1_q;
    end
  end

  function automatic logic [63:0] got_word();
    logic [63:0] w;
    for (int j = 0; j < 4; j++) w[16*j +: 16] = data_out[j];
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int k);
    check_eq($sformatf("%s_valid_w%0d", tag, k), 64'(data_out_valid), 64'd1);
    check_eq($sformatf("%s_data_w%0d", tag, k), got_word(), exp_word(k));
    check_eq($sformatf("%s_last_w%0d", tag, k), 64'(data_out_last), (k == 31) ? 64'd1 : 64'd0);
  endtask

  initial begin
    int hs;
    rst = 1'b0;
    data_out_ready = 1'b1;
    #2;
    check_eq("rst_valid", 64'(data_out_valid), 64'd0);
    check_eq("rst_last", 64'(data_out_last), 64'd0);
    check_eq("rst_pass", 64'(pass_count), 64'd0);
    check_eq("rst_addr", 64'(rom_addr), 64'd0);
    check_eq("rst_ce", 64'(rom_ce), 64'd1);

    // Test 1: latency, full pass at one word per cycle, lane unpacking.
    @(negedge clk);
    rst = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      check_eq($sformatf("t1_lat_e%0d", e), 64'(data_out_valid), 64'd0);
    end
    @(negedge clk);
    chk_beat("t1", 0);
    check_eq("t5_lane0", 64'(data_out[0]), 64'h0A);
    check_eq("t5_lane1", 64'(data_out[1]), 64'h0B);
    check_eq("t5_lane2", 64'(data_out[2]), 64'h0C);
    check_eq("t5_lane3", 64'(data_out[3]), 64'h0D);
    check_eq("t1_pass_before", 64'(pass_count), 64'd0);
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      chk_beat("t1", k);
    end
    @(negedge clk);
    check_eq("t1_pass_after", 64'(pass_count), 64'd1);
    chk_beat("t1_wrap", 0);
    for (int k = 1; k < 18; k++) begin
      @(negedge clk);
      chk_beat("t1_p2", k);
    end

    // Test 4: reset while word 17 is at the head and later words in flight.
    rst = 1'b0;
    data_out_ready = 1'b0;
    #1;
    check_eq("t4_valid", 64'(data_out_valid), 64'd0);
    check_eq("t4_last", 64'(data_out_last), 64'd0);
    check_eq("t4_pass", 64'(pass_count), 64'd0);
    check_eq("t4_addr", 64'(rom_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      check_eq($sformatf("t4_restart_e%0d", e), 64'(data_out_valid), 64'd0);
    end
    @(negedge clk);
    chk_beat("t4_restart", 0);

    // Test 2: ready has been low since E0; 20 cycles of backpressure.
    repeat (5) @(negedge clk);
    chk_beat("t2_hold_a", 0);
    repeat (11) @(negedge clk);
    chk_beat("t2_hold_b", 0);
    check_eq("t2_issues", 64'(rom_addr), 64'd4);
    data_out_ready = 1'b1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      chk_beat("t2_drain", k);
    end

    // Test 3: random ready over three passes from a fresh reset.
    @(negedge clk);
    rst = 1'b0;
    data_out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    hs = 0;
    for (int c = 0; c < 3000 && hs < 96; c++) begin
      @(negedge clk);
      data_out_ready = 1'($urandom_range(0, 1));
      if (data_out_valid && data_out_ready) begin
        chk_beat("t3", hs % 32);
        hs++;
      end
    end
    check_eq("t3_handshakes", 64'(hs), 64'd96);
    @(negedge clk);
    data_out_ready = 1'b0;
    check_eq("t3_pass", 64'(pass_count), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
